line_refill_ctrl: RTL and testbench

//  Refill engine for the BIU line buffer. Consumes the tag arbiter's miss request and replacement

---
 rtl/line_refill_ctrl.sv | 89 ++++++++
 tb/tb_line_refill_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/line_refill_ctrl.sv
// line_refill_ctrl: fetches one cache line as a burst, writes it into the entry data RAM, then signals the tag arbiter to install it
//  miss_req/miss_addr/replace_sel/flush : miss request, address, victim entry and valid_clear from the tag arbiter
//  bus_req/bus_addr/bus_ack              : burst read request handshake (line-aligned base address)
//  bus_rvalid/bus_rdata/bus_err          : read beats and error
//  ram_we/ram_entry/ram_word/ram_wdata   : data RAM write port, one cycle behind each accepted beat
//  line_refill/refill_pa                 : one-cycle install pulse with line base address
//  busy/refill_err                       : not IDLE / aborted refill pulse
module line_refill_ctrl #(
  parameter int ENTRY_NUM  = 8,
  parameter int SEL_WIDTH  = ENTRY_NUM > 1 ? $clog2(ENTRY_NUM) : 1,
  parameter int LINE_WORDS = 8,
  parameter int WORD_SEL   = $clog2(LINE_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_req,
  input  logic [31:0]          miss_addr,
  input  logic [SEL_WIDTH-1:0] replace_sel,
  input  logic                 flush,
  output logic                 bus_req,
  output logic [31:0]          bus_addr,
  input  logic                 bus_ack,
  input  logic                 bus_rvalid,
  input  logic [31:0]          bus_rdata,
  input  logic                 bus_err,
  output logic                 ram_we,
  output logic [SEL_WIDTH-1:0] ram_entry,
  output logic [WORD_SEL-1:0]  ram_word,
  output logic [31:0]          ram_wdata,
  output logic                 line_refill,
  output logic [31:0]          refill_pa,
  output logic                 busy,
  output logic                 refill_err
);
  typedef enum logic [1:0] {IDLE, REQ, BEAT, COMMIT} state_t;
  localparam logic [31:0] OFF_MASK = 32'(LINE_WORDS * 4 - 1);
  state_t state, nxt;
  logic [WORD_SEL-1:0] cnt;
  logic flush_pend, refill_q, beat, last, beat_err;
  assign beat     = state == BEAT && bus_rvalid && !bus_err;
  assign beat_err = state == BEAT && bus_rvalid && bus_err;
  assign last     = beat && cnt == WORD_SEL'(LINE_WORDS - 1);
  // a flush arriving in the COMMIT cycle itself must still kill the install
  assign line_refill = refill_q && !flush;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = miss_req && !flush ? REQ : IDLE;
      REQ:     nxt = bus_err ? IDLE : bus_ack ? BEAT : REQ;
      BEAT:    nxt = beat_err ? IDLE : last ? COMMIT : BEAT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      bus_req    <= 1'b0;
      bus_addr   <= '0;
      ram_we     <= 1'b0;
      ram_entry  <= '0;
      ram_word   <= '0;
      ram_wdata  <= '0;
      refill_q   <= 1'b0;
      refill_pa  <= '0;
      busy       <= 1'b0;
      refill_err <= 1'b0;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      bus_req    <= nxt == REQ;
      busy       <= nxt != IDLE;
      refill_err <= (state == REQ && bus_err) || beat_err;
      ram_we     <= beat;
      if (state == IDLE && nxt == REQ) begin
        bus_addr  <= miss_addr & ~OFF_MASK;
        ram_entry <= replace_sel;
      end
      if (beat) begin
        ram_word  <= cnt;
        ram_wdata <= bus_rdata;
      end
      cnt        <= state == REQ ? '0 : beat ? cnt + 1'b1 : cnt;
      flush_pend <= nxt == IDLE ? 1'b0 : (state != IDLE && flush) ? 1'b1 : flush_pend;
      refill_q   <= nxt == COMMIT && !flush_pend && !flush;
      if (nxt == COMMIT) refill_pa <= bus_addr;
    end
endmodule

// File: tb/tb_line_refill_ctrl.sv
// tb_line_refill_ctrl: directed stimulus with scoreboard queues checked by a separate output monitor
module tb_line_refill_ctrl;
  logic clk = 0, rst = 1, miss_req = 0, flush = 0, bus_ack = 0, bus_rvalid = 0, bus_err = 0;
  logic [31:0] miss_addr = 0, bus_rdata = 0, bus_addr, ram_wdata, refill_pa;
  logic [2:0] replace_sel = 0, ram_entry, ram_word;
  logic bus_req, ram_we, line_refill, busy, refill_err;
  line_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr), .replace_sel(replace_sel),
    .flush(flush), .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .ram_we(ram_we), .ram_entry(ram_entry), .ram_word(ram_word),
    .ram_wdata(ram_wdata), .line_refill(line_refill), .refill_pa(refill_pa), .busy(busy), .refill_err(refill_err)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cyc = 0, ref_cyc = -1, err_cnt = 0;
  logic [31:0] bus_q[$], ref_q[$];
  logic [47:0] wr_q[$];
  logic breq_d = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (bus_req === 1'b1 && !breq_d) begin
      chk("bus_req_expected", bus_q.size() > 0, 1);
      if (bus_q.size() > 0) chk("bus_addr", bus_addr, bus_q.pop_front());
    end
    breq_d = bus_req === 1'b1;
    if (ram_we === 1'b1) begin
      chk("ram_we_expected", wr_q.size() > 0, 1);
      if (wr_q.size() > 0) chk("ram_write", {8'(ram_entry), 8'(ram_word), ram_wdata}, wr_q.pop_front());
    end
    if (line_refill === 1'b1) begin
      ref_cyc = cyc;
      chk("line_refill_expected", ref_q.size() > 0, 1);
      if (ref_q.size() > 0) chk("refill_pa", refill_pa, ref_q.pop_front());
    end
    if (refill_err === 1'b1) begin
      chk("refill_err_expected", err_cnt > 0, 1);
      if (err_cnt > 0) err_cnt--;
    end
  end
  task automatic outs_zero(input string nm);
    chk(nm, {bus_req, ram_we, line_refill, busy, refill_err, bus_addr, refill_pa, 5'(ram_entry), 5'(ram_word), ram_wdata}, 0);
  endtask
  task automatic refill(input logic [31:0] addr, input logic [2:0] sel, input int ack_dly, input logic [7:0] gaps,
                        input int err_beat, input int flush_beat, input int rst_beat, input bit tog, input int lat);
    logic [31:0] base;
    int c0, last;
    bit ok;
    base = addr & 32'hffff_ffe0;
    ok = 1;
    last = 0;
    ref_cyc = -1;
    bus_q.push_back(base);
    c0 = cyc;
    miss_req = 1; miss_addr = addr; replace_sel = sel;
    tick();
    miss_req = 0;
    chk("busy_req", busy, 1);
    repeat (ack_dly) tick();
    bus_ack = 1;
    tick();
    bus_ack = 0;
    for (int i = 0; i < 8; i++) begin
      bus_rvalid = 1; bus_rdata = 32'hA0 + i; miss_req = tog & i[0];
      if (i == rst_beat) begin
        rst = 1;
        tick();
        rst = 0;
        outs_zero("rst_mid_outputs");
        for (int j = i + 1; j < 8; j++) begin
          bus_rdata = 32'hA0 + j;
          tick();
        end
        bus_rvalid = 0; miss_req = 0;
        tick();
        chk("busy_after_rst", busy, 0);
        return;
      end
      if (i == err_beat) begin
        bus_err = 1; err_cnt++;
        tick();
        bus_err = 0; bus_rvalid = 0; miss_req = 0; ok = 0;
        break;
      end
      flush = i == flush_beat;
      wr_q.push_back({8'(sel), 8'(i), 32'hA0 + i});
      last = cyc;
      tick();
      bus_rvalid = 0; flush = 0; miss_req = 0;
      chk("busy_beat", busy, 1);
      if (gaps[i]) repeat (2) tick();
    end
    if (ok) begin
      if (flush_beat < 0) ref_q.push_back(base);
      tick();
      if (flush_beat < 0) chk("refill_after_last_beat", ref_cyc, last + 1);
      else chk("no_refill_flushed", ref_cyc, -1);
      if (lat >= 0) chk("refill_latency", ref_cyc - c0, lat);
    end else chk("no_refill_err", ref_cyc, -1);
    chk("busy_done", busy, 0);
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) tick();
    outs_zero("reset_outputs");
    rst = 0;
    tick();
    outs_zero("idle_outputs");
    refill(32'h0000_1234, 3, 0, 8'h00, -1, -1, -1, 0, 10);
    refill(32'h0000_1234, 3, 5, 8'b0010_0100, -1, -1, -1, 0, -1);
    refill(32'h8000_0044, 5, 1, 8'h00, 4, -1, -1, 0, -1);
    refill(32'h0000_ABCD, 1, 0, 8'h00, -1, 2, -1, 0, -1);
    refill(32'h0000_2040, 6, 0, 8'h00, -1, -1, 3, 0, -1);
    refill(32'hFFFF_FFFC, 7, 2, 8'h01, -1, -1, -1, 0, -1);
    miss_req = 1; flush = 1; miss_addr = 32'h5555_0000;
    tick();
    miss_req = 0; flush = 0;
    chk("flush_miss_no_req", bus_req, 0);
    chk("flush_miss_idle", busy, 0);
    tick();
    chk("flush_miss_no_req2", bus_req, 0);
    refill(32'h3000_0010, 2, 1, 8'h00, -1, -1, -1, 1, -1);
    repeat (3) tick();
    chk("bus_q_empty", bus_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("ref_q_empty", ref_q.size(), 0);
    chk("err_all_seen", err_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
